// File: rtl/maxpool_pkg.sv
// ============================================================================
// Module      : maxpool_pkg
// Description : Shared state encoding and frame-size constants for the
//               2x2 stride-2 max-pooling sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package maxpool_pkg;

    localparam int c_DEFAULT_COLS = 30;
    localparam int c_DEFAULT_ROWS = 30;
    localparam int c_DEFAULT_POOL_SIZE = (c_DEFAULT_ROWS / 2) * (c_DEFAULT_COLS / 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/maxpool_wrap_cnt.sv
// ============================================================================
// Module      : maxpool_wrap_cnt
// Description : Modulo-MOD counter with enable, synchronous clear and a wrap
//               strobe that is high when an enabled count rolls over.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_wrap_cnt #(
    parameter int W   = 5,
    parameter int MOD = 30
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         iEN,
    input  logic         iCLR,
    output logic [W-1:0] oCNT,
    output logic         oWRAP
);

    localparam logic [W-1:0] c_LAST = W'(MOD - 1);

    assign oWRAP = iEN && (oCNT == c_LAST);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oCNT <= '0;
        end else if (iCLR) begin
            oCNT <= '0;
        end else if (iEN) begin
            oCNT <= oWRAP ? '0 : oCNT + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/maxpool_ctrl.sv
// ============================================================================
// Module      : maxpool_ctrl
// Description : Frame sequencer for the 2x2 stride-2 binary max-pool line
//               buffer. Optional MAXPOOL_CTRL_ERR_EN builds the sticky oERR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_ctrl
    import maxpool_pkg::*;
#(
    parameter int COLS = c_DEFAULT_COLS,
    parameter int ROWS = c_DEFAULT_ROWS,
    parameter int CW   = 5,
    parameter int RW   = 5,
    parameter int OW   = 8
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iSTART,
    input  logic          iVALID,
    output logic          oREADY,
    output logic          oSR_EN,
    output logic          oSR_CLR,
    output logic [CW-1:0] oCOL,
    output logic [RW-1:0] oROW,
    output logic          oPOOL_VALID,
    input  logic          iPOOL_READY,
    output logic [OW-1:0] oOUT_IDX,
    output logic          oBUSY,
    output logic          oDONE,
    output logic          oERR
);

    state_t          r_state;
    logic            r_poolValid;
    logic [OW-1:0]   r_outIdx;
    logic            r_srClr;
    logic            r_done;
    logic            r_busy;

    logic            w_xfer;
    logic            w_poolTake;
    logic            w_windowDone;
    logic            w_colWrap;
    logic            w_rowWrap;
    logic            w_cntClr;

    // Stall the stream while a pooled result is pending so the window is not shifted away.
    assign oREADY       = (r_state == RUN) && !(r_poolValid && !iPOOL_READY);
    assign w_xfer       = iVALID && oREADY;
    assign w_poolTake   = r_poolValid && iPOOL_READY;
    assign w_windowDone = w_xfer && oCOL[0] && oROW[0];
    assign w_cntClr     = (r_state == CLEAR);

    assign oSR_EN      = w_xfer;
    assign oSR_CLR     = r_srClr;
    assign oPOOL_VALID = r_poolValid;
    assign oOUT_IDX    = r_outIdx;
    assign oBUSY       = r_busy;
    assign oDONE       = r_done;

    maxpool_wrap_cnt #(.W(CW), .MOD(COLS)) u_colCnt (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iEN   (w_xfer),
        .iCLR  (w_cntClr),
        .oCNT  (oCOL),
        .oWRAP (w_colWrap)
    );

    maxpool_wrap_cnt #(.W(RW), .MOD(ROWS)) u_rowCnt (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iEN   (w_colWrap),
        .iCLR  (w_cntClr),
        .oCNT  (oROW),
        .oWRAP (w_rowWrap)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state     <= IDLE;
            r_poolValid <= 1'b0;
            r_outIdx    <= '0;
            r_srClr     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_srClr <= 1'b0;
            r_done  <= 1'b0;

            // A completing window wins over a simultaneous take: the flag stays set.
            if (w_windowDone) begin
                r_poolValid <= 1'b1;
            end else if (w_poolTake) begin
                r_poolValid <= 1'b0;
            end
            if (w_poolTake) begin
                r_outIdx <= r_outIdx + OW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (iSTART) begin
                        r_state <= CLEAR;
                        r_srClr <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: r_state <= RUN;
                RUN: begin
                    if (w_rowWrap) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!r_poolValid || iPOOL_READY) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_outIdx <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MAXPOOL_CTRL_ERR_EN
    logic r_idleValid;
    logic r_err;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_idleValid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_idleValid <= (r_state == IDLE) && iVALID;
            if ((iSTART && r_busy) || ((r_state == IDLE) && iVALID && r_idleValid)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign oERR = r_err;
`else
    assign oERR = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/maxpool_ctrl.md
Name: maxpool_ctrl

Overview:
Frame-level sequencer for the binary 2x2, stride-2 max-pooling line-buffer datapath. It accepts a raster-order pixel stream over a valid/ready handshake and drives the shift-register enable and clear. It tracks row and column position and emits a pooled-result valid strobe exactly when a complete 2x2 window sits in the line buffer. It sits between the STFT binarisation stage and the pooling datapath, and holds the stream off while a downstream consumer stalls.

Parameters:
COLS, 30, pixels per line (even, >=2); equals the datapath line length.
ROWS, 30, lines per frame (even, >=2).
CW, 5, column counter width; 2**CW >= COLS.
RW, 5, row counter width; 2**RW >= ROWS.
OW, 8, pooled-output index width; 2**OW >= (ROWS/2)*(COLS/2).

Ports:
iCLK  in  1  clock, rising edge.
iRST  in  1  reset; asynchronous, active-high.
iSTART  in  1  one-cycle frame start request.
iVALID  in  1  upstream pixel valid.
oREADY  out  1  upstream ready; a pixel transfers when iVALID&&oREADY.
oSR_EN  out  1  datapath shift enable; equals iVALID&&oREADY, combinational.
oSR_CLR  out  1  datapath synchronous clear.
oCOL  out  CW  column of the next pixel to accept.
oROW  out  RW  row of the next pixel to accept.
oPOOL_VALID  out  1  pooled result available at the datapath output.
iPOOL_READY  in  1  downstream accepts the pooled result.
oOUT_IDX  out  OW  index of the current pooled result, 0-based, raster order.
oBUSY  out  1  high in any state other than IDLE.
oDONE  out  1  one-cycle pulse at end of frame.
oERR  out  1  sticky protocol error (optional feature only).

Behaviour:
- Reset (async, iRST=1): state=IDLE; oCOL=0, oROW=0, oOUT_IDX=0; oPOOL_VALID=0, oSR_CLR=0, oDONE=0, oBUSY=0, oERR=0. oREADY and oSR_EN are 0 because the state is IDLE. Reset mid-frame abandons the frame; no oDONE is issued.
- States:
  - IDLE: oREADY=0. iSTART -> CLEAR.
  - CLEAR: one cycle. oSR_CLR=1. Counters zeroed -> RUN.
  - RUN: oREADY = !(oPOOL_VALID && !iPOOL_READY).
    - On each transfer, oCOL increments; wrap at COLS-1 -> 0 with oROW+1.
    - On transfer of pixel (ROWS-1, COLS-1) -> DRAIN.
  - DRAIN: oREADY=0. Wait until oPOOL_VALID=0, or oPOOL_VALID&&iPOOL_READY in this cycle -> DONE.
  - DONE: oDONE=1 for one cycle. oOUT_IDX cleared -> IDLE.
- Window detect: a transfer with oCOL[0]=1 and oROW[0]=1 sets oPOOL_VALID, registered, on the next cycle. At that point the datapath holds the completed window.
- oPOOL_VALID clears on iPOOL_READY. oOUT_IDX increments on each oPOOL_VALID&&iPOOL_READY.
- A new window cannot set oPOOL_VALID while it is still held high. Backpressure guarantees this: oREADY=0 while stalled, so the line buffer never shifts under a pending result.
- oPOOL_VALID&&iPOOL_READY in the same cycle as a window-completing transfer: the flag stays 1 (clear and set coincide) and oOUT_IDX increments.
- Latency: first oPOOL_VALID occurs one cycle after the (COLS+2)-th transfer, i.e. pixel (1,1).
- iSTART outside IDLE is ignored. iVALID in IDLE, CLEAR, DRAIN or DONE is not accepted.
- Exactly (ROWS/2)*(COLS/2) pooled strobes per frame.

Optional Feature:
MAXPOOL_CTRL_ERR_EN.
- Defined: oERR is set, sticky until iRST, when either occurs:
  - iSTART while oBUSY=1;
  - iVALID=1 in IDLE for 2 or more consecutive cycles.
- Undefined: oERR is tied 0 and no detection logic is built.

Decomposition:
- Package maxpool_pkg:
  - state encoding constants: IDLE, CLEAR, RUN, DRAIN, DONE;
  - default COLS/ROWS;
  - derived pooled-frame size constant.
- One sub-module, maxpool_wrap_cnt: parameterised modulo counter with enable, clear, wrap output and async active-high reset. It is instantiated for column and row.

Test Plan:
1. Reset: assert iRST mid-cycle -> all outputs 0 immediately, state IDLE; release, oREADY stays 0.
2. Full 30x30 frame, iVALID=1, iPOOL_READY=1 -> oSR_CLR one cycle after iSTART.
   - First oPOOL_VALID the cycle after the 32nd transfer.
   - 225 strobes total with oOUT_IDX 0..224.
   - oDONE one cycle after DRAIN; oBUSY returns 0.
3. Backpressure: iPOOL_READY=0 for 5 cycles at the first window -> oREADY=0 for those cycles, no oSR_EN, oOUT_IDX held at 0; resumes on iPOOL_READY=1.
4. Gapped input: iVALID random 50% -> oCOL/oROW advance only on transfers; still exactly 225 strobes; final oROW/oCOL back to 0 after DONE.
5. iRST at pixel (10,7) then a new iSTART -> no oDONE from the aborted frame; the new frame yields 225 strobes.
6. With MAXPOOL_CTRL_ERR_EN: iSTART during RUN -> oERR=1 and held, frame completes normally. Without the macro -> oERR stays 0.
